// File: rtl/rcc_pkg.sv
// rcc_pkg: shared types and default constants for the RCC clock
// switch sequencer.
package rcc_pkg;

  localparam int RCC_NUM_SRC    = 4;
  localparam int RCC_SEL_W      = 2;
  localparam int RCC_DIV_W      = 4;
  localparam int RCC_MUX_DELAY  = 4;
  localparam int RCC_SYNC_DELAY = 3;
  localparam int RCC_RST_DELAY  = 8;
  localparam int RCC_DEF_SEL    = 0;
  localparam int RCC_DEF_DIV    = 1;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_GATE_OFF,
    ST_SWITCH,
    ST_RST_HOLD
  } rcc_sw_state_e;

  typedef struct packed {
    logic [RCC_SEL_W-1:0] sel;
    logic [RCC_DIV_W-1:0] div;
  } rcc_sw_req_t;

  function automatic int rcc_max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rcc_defines.svh
// rcc_defines: macro mirror of the rcc_pkg widths and default delays
// for code that cannot import the package.
`ifndef RCC_DEFINES_SVH
`define RCC_DEFINES_SVH

`define RCC_NUM_SRC    4
`define RCC_SEL_W      2
`define RCC_DIV_W      4
`define RCC_MUX_DELAY  4
`define RCC_SYNC_DELAY 3
`define RCC_RST_DELAY  8
`define RCC_DEF_SEL    0
`define RCC_DEF_DIV    1

`endif

// File: rtl/rcc_delay_cnt.sv
// rcc_delay_cnt: loadable down-counter that parks at zero; shared by
// every timed state of the switch sequencer.
module rcc_delay_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      cnt <= load_val_i;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/rcc_clk_switch_seq.sv
// rcc_clk_switch_seq: glitch-safe clock source/divider switch sequencer
// that gates the SDRAM clock and holds its reset across every change.
module rcc_clk_switch_seq
  import rcc_pkg::*;
#(
  parameter int NUM_SRC    = RCC_NUM_SRC,
  parameter int SEL_W      = RCC_SEL_W,
  parameter int DIV_W      = RCC_DIV_W,
  parameter int MUX_DELAY  = RCC_MUX_DELAY,
  parameter int SYNC_DELAY = RCC_SYNC_DELAY,
  parameter int RST_DELAY  = RCC_RST_DELAY,
  parameter int DEF_SEL    = RCC_DEF_SEL,
  parameter int DEF_DIV    = RCC_DEF_DIV
) (
  input  logic             clk_i,
  input  logic             hw_rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [SEL_W-1:0] req_sel_i,
  input  logic [DIV_W-1:0] req_div_i,
  output logic [SEL_W-1:0] mux_sel_o,
  output logic [DIV_W-1:0] div_o,
  output logic             clk_gate_en_o,
  output logic             sdram_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int MAX_DLY =
    rcc_max3(MUX_DELAY, SYNC_DELAY, RST_DELAY);
  localparam int CNT_W = $clog2(MAX_DLY) + 1;

  localparam logic [CNT_W-1:0] MUX_LD =
    CNT_W'(MUX_DELAY - 1);
  localparam logic [CNT_W-1:0] SYNC_LD =
    CNT_W'(SYNC_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_LD =
    CNT_W'(RST_DELAY - 1);

  localparam logic [SEL_W:0] NSRC = (SEL_W+1)'(NUM_SRC);

  rcc_sw_state_e    state;
  rcc_sw_req_t      hold;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             req_bad;
  logic             req_nop;
  logic             req_go;

  assign req_bad = ({1'b0, req_sel_i} >= NSRC)
                || (req_div_i == '0);
  assign req_nop = !req_bad
                && (req_sel_i == mux_sel_o)
                && (req_div_i == div_o);
  assign req_go  = req_valid_i && !req_bad && !req_nop;

  // Each timed state gets its delay loaded on its entry edge.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (hw_rst_i) begin
      cnt_load = 1'b1;
      cnt_val  = RST_LD;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_go) begin
            cnt_load = 1'b1;
            cnt_val  = MUX_LD;
          end
        end
        ST_GATE_OFF: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = SYNC_LD;
          end
        end
        ST_SWITCH: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = RST_LD;
          end
        end
        default: begin
          cnt_load = 1'b0;
        end
      endcase
    end
  end

  rcc_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_dly (
    .clk_i      (clk_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (hw_rst_i) begin
      state         <= ST_BOOT;
      mux_sel_o     <= SEL_W'(DEF_SEL);
      div_o         <= DIV_W'(DEF_DIV);
      clk_gate_en_o <= 1'b1;
      sdram_rst_o   <= 1'b1;
      busy_o        <= 1'b1;
      req_ready_o   <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          if (cnt_zero) begin
            state       <= ST_IDLE;
            sdram_rst_o <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid_i) begin
            hold.sel <= req_sel_i;
            hold.div <= req_div_i;
            unique case (1'b1)
              req_bad: err_o  <= 1'b1;
              req_nop: done_o <= 1'b1;
              default: begin
                state         <= ST_GATE_OFF;
                clk_gate_en_o <= 1'b0;
                sdram_rst_o   <= 1'b1;
                busy_o        <= 1'b1;
                req_ready_o   <= 1'b0;
              end
            endcase
          end
        end
        ST_GATE_OFF: begin
          // Gate is already off, so sel and div move together safely.
          if (cnt_zero) begin
            state     <= ST_SWITCH;
            mux_sel_o <= hold.sel;
            div_o     <= hold.div;
          end
        end
        ST_SWITCH: begin
          if (cnt_zero) begin
            state         <= ST_RST_HOLD;
            clk_gate_en_o <= 1'b1;
          end
        end
        ST_RST_HOLD: begin
          if (cnt_zero) begin
            state       <= ST_IDLE;
            sdram_rst_o <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
            done_o      <= 1'b1;
          end
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_clk_switch_seq.sv
// tb_rcc_clk_switch_seq: directed scenarios plus random traffic checked
// against a timeline model of the switch sequencer.
module tb_rcc_clk_switch_seq;

  localparam int NSRC  = 3;
  localparam int MUX   = 4;
  localparam int SYNC  = 3;
  localparam int RST   = 8;
  localparam int END_K = MUX + SYNC + RST;

  logic       clk_i = 1'b0;
  logic       hw_rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [1:0] req_sel_i;
  logic [3:0] req_div_i;
  logic [1:0] mux_sel_o;
  logic [3:0] div_o;
  logic       clk_gate_en_o;
  logic       sdram_rst_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  always #5 clk_i = ~clk_i;

  rcc_clk_switch_seq #(
    .NUM_SRC (NSRC)
  ) dut (
    .clk_i         (clk_i),
    .hw_rst_i      (hw_rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_sel_i     (req_sel_i),
    .req_div_i     (req_div_i),
    .mux_sel_o     (mux_sel_o),
    .div_o         (div_o),
    .clk_gate_en_o (clk_gate_en_o),
    .sdram_rst_o   (sdram_rst_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Timeline model: either a boot or a switch that began at m_t0.
  bit         m_boot;
  int         m_t0;
  int         m_done_at;
  int         m_err_at;
  logic [1:0] m_old_sel;
  logic [1:0] m_new_sel;
  logic [3:0] m_old_div;
  logic [3:0] m_new_div;

  // {ready, sel[1:0], div[3:0], gate, rst, busy, done, err}
  function automatic logic [11:0] exp_vec(input int c);
    logic       b;
    logic       g;
    logic       dn;
    logic       er;
    logic [1:0] s;
    logic [3:0] d;
    int         k;
    k  = c - m_t0;
    dn = (c == m_done_at);
    er = (c == m_err_at);
    if (m_boot) begin
      s = 2'd0;
      d = 4'd1;
      b = (k < RST);
      g = 1'b1;
    end else begin
      s  = (k <= MUX) ? m_old_sel : m_new_sel;
      d  = (k <= MUX) ? m_old_div : m_new_div;
      g  = !(k >= 1 && k <= MUX + SYNC);
      b  = (k >= 1 && k <= END_K);
      if (k == END_K + 1) dn = 1'b1;
    end
    return {!b, s, d, g, b, b, dn, er};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {req_ready_o, mux_sel_o, div_o, clk_gate_en_o,
            sdram_rst_o, busy_o, done_o, err_o};
  endfunction

  task automatic tick(input bit r, input bit v,
                      input logic [1:0] s, input logic [3:0] d);
    logic [11:0] e;
    e = exp_vec(cyc);
    hw_rst_i    = r;
    req_valid_i = v;
    req_sel_i   = s;
    req_div_i   = d;
    if (r) begin
      m_boot    = 1'b1;
      m_t0      = cyc + 1;
      m_done_at = -1;
      m_err_at  = -1;
    end else if (v && e[11]) begin
      if (int'(s) >= NSRC || d == 4'd0) begin
        m_err_at = cyc + 1;
      end else if (s == e[10:9] && d == e[8:5]) begin
        m_done_at = cyc + 1;
      end else begin
        m_boot    = 1'b0;
        m_t0      = cyc;
        m_old_sel = e[10:9];
        m_old_div = e[8:5];
        m_new_sel = s;
        m_new_div = d;
      end
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h",
                 cyc, obs_vec(), exp_vec(cyc));
      end
      tick(1'b1, 1'b0, 2'd0, 4'd0);
    end
    for (int i = 0; i <= RST + 2; i++) begin
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL boot cyc=%0d got=%h exp=%h",
                 cyc, obs_vec(), exp_vec(cyc));
      end
      if (i == RST - 1) begin
        checks++;
        if (sdram_rst_o !== 1'b1 || req_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL boot_hold rst=%b rdy=%b exp 1 0",
                   sdram_rst_o, req_ready_o);
        end
      end
      if (i == RST) begin
        checks++;
        if (sdram_rst_o !== 1'b0 || req_ready_o !== 1'b1 ||
            mux_sel_o !== 2'd0 || div_o !== 4'd1) begin
          errors++;
          $display("FAIL boot_release rst=%b rdy=%b sel=%0d div=%0d",
                   sdram_rst_o, req_ready_o, mux_sel_o, div_o);
        end
      end
      checks++;
      if (done_o !== 1'b0) begin
        errors++;
        $display("FAIL boot_no_done got=%b exp=0", done_o);
      end
      tick(1'b0, 1'b0, 2'd0, 4'd0);
    end
  endtask

  task automatic test_switch();
    for (int k = 0; k <= END_K + 3; k++) begin
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL switch k=%0d got=%h exp=%h",
                 k, obs_vec(), exp_vec(cyc));
      end
      if (k == MUX) begin
        checks++;
        if (mux_sel_o !== 2'd0 || clk_gate_en_o !== 1'b0) begin
          errors++;
          $display("FAIL switch_pre sel=%0d gate=%b exp 0 0",
                   mux_sel_o, clk_gate_en_o);
        end
      end
      if (k == MUX + 1) begin
        checks++;
        if (mux_sel_o !== 2'd2 || div_o !== 4'd3) begin
          errors++;
          $display("FAIL switch_load sel=%0d div=%0d exp 2 3",
                   mux_sel_o, div_o);
        end
      end
      if (k == MUX + SYNC + 1) begin
        checks++;
        if (clk_gate_en_o !== 1'b1 || sdram_rst_o !== 1'b1) begin
          errors++;
          $display("FAIL switch_gate gate=%b rst=%b exp 1 1",
                   clk_gate_en_o, sdram_rst_o);
        end
      end
      if (k == END_K + 1) begin
        checks++;
        if (done_o !== 1'b1 || sdram_rst_o !== 1'b0) begin
          errors++;
          $display("FAIL switch_done done=%b rst=%b exp 1 0",
                   done_o, sdram_rst_o);
        end
      end
      tick(1'b0, k == 0, 2'd2, 4'd3);
    end
  endtask

  task automatic test_nop();
    for (int k = 0; k <= 5; k++) begin
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL nop k=%0d got=%h exp=%h",
                 k, obs_vec(), exp_vec(cyc));
      end
      checks++;
      if (clk_gate_en_o !== 1'b1 || sdram_rst_o !== 1'b0 ||
          done_o !== (k == 1)) begin
        errors++;
        $display("FAIL nop_ctl k=%0d gate=%b rst=%b done=%b",
                 k, clk_gate_en_o, sdram_rst_o, done_o);
      end
      tick(1'b0, k == 0, 2'd2, 4'd3);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] s;
    logic [3:0] d;
    for (int n = 0; n < 2; n++) begin
      s = (n == 0) ? 2'd3 : 2'd1;
      d = (n == 0) ? 4'd3 : 4'd0;
      for (int k = 0; k <= 3; k++) begin
        checks++;
        if (obs_vec() !== exp_vec(cyc)) begin
          errors++;
          $display("FAIL illegal n=%0d k=%0d got=%h exp=%h",
                   n, k, obs_vec(), exp_vec(cyc));
        end
        if (k == 1) begin
          checks++;
          if (err_o !== 1'b1 || done_o !== 1'b0 ||
              mux_sel_o !== 2'd2 || div_o !== 4'd3 ||
              clk_gate_en_o !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err n=%0d err=%b sel=%0d div=%0d",
                     n, err_o, mux_sel_o, div_o);
          end
        end
        tick(1'b0, k == 0, s, d);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit         v;
    logic [1:0] s;
    logic [3:0] d;
    for (int k = 0; k <= 2 * END_K + 4; k++) begin
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL b2b k=%0d got=%h exp=%h",
                 k, obs_vec(), exp_vec(cyc));
      end
      if (k == END_K + 1) begin
        checks++;
        if (done_o !== 1'b1 || req_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done done=%b rdy=%b exp 1 1",
                   done_o, req_ready_o);
        end
      end
      if (k == END_K + 2) begin
        checks++;
        if (clk_gate_en_o !== 1'b0 || mux_sel_o !== 2'd1 ||
            div_o !== 4'd5) begin
          errors++;
          $display("FAIL b2b_accept gate=%b sel=%0d div=%0d",
                   clk_gate_en_o, mux_sel_o, div_o);
        end
      end
      v = (k == 0) || (k >= MUX + 2 && k <= END_K + 1);
      s = (k == 0) ? 2'd1 : 2'd0;
      d = (k == 0) ? 4'd5 : 4'd7;
      tick(1'b0, v, s, d);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= RST + 6; k++) begin
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL rst_mid k=%0d got=%h exp=%h",
                 k, obs_vec(), exp_vec(cyc));
      end
      if (k == 3) begin
        checks++;
        if (mux_sel_o !== 2'd0 || div_o !== 4'd1 ||
            clk_gate_en_o !== 1'b1 || sdram_rst_o !== 1'b1 ||
            busy_o !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_defaults sel=%0d div=%0d gate=%b rst=%b",
                   mux_sel_o, div_o, clk_gate_en_o, sdram_rst_o);
        end
      end
      if (k == 3 + RST) begin
        checks++;
        if (sdram_rst_o !== 1'b0 || req_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_reboot rst=%b rdy=%b exp 0 1",
                   sdram_rst_o, req_ready_o);
        end
      end
      tick(k == 2, k == 0, 2'd2, 4'd9);
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    bit          r;
    bit          v;
    logic [1:0]  s;
    logic [3:0]  d;
    for (int i = 0; i < 400; i++) begin
      e = exp_vec(cyc);
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL random i=%0d cyc=%0d got=%h exp=%h",
                 i, cyc, obs_vec(), e);
      end
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 2) != 0);
      s = 2'($urandom_range(0, 3));
      d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        s = e[10:9];
        d = e[8:5];
      end
      tick(r, v, s, d);
    end
  endtask

  initial begin
    hw_rst_i    = 1'b1;
    req_valid_i = 1'b0;
    req_sel_i   = 2'd0;
    req_div_i   = 4'd0;
    m_boot      = 1'b1;
    m_t0        = 0;
    m_done_at   = -1;
    m_err_at    = -1;
    m_old_sel   = 2'd0;
    m_new_sel   = 2'd0;
    m_old_div   = 4'd1;
    m_new_div   = 4'd1;
    @(negedge clk_i);
    test_reset();
    test_switch();
    test_nop();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
